lc3_mem_arbiter: RTL

//  Shares the single-port LC3 data/instruction memory between the CPU (MAR/MDR path of the
//  LC3 controller) and a DMA/loader port. Arbitrates round-robin, registers the granted request,

---
 rtl/lc3_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing the single-port LC3 memory between the CPU and a DMA/loader port.
// Handshake: req is a level held until the one-cycle ack; requests are sampled only in IDLE.
module lc3_mem_arbiter #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                MEM_LAT   = 1,
    parameter logic [ADDR_W-1:0] PROT_BASE = 16'h3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic              dma_err,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              hold_we_q, hold_we_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
    logic              owner_q, owner_d;          // 1 = DMA
    logic              last_grant_q, last_grant_d; // 1 = DMA
    logic              err_q, err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic grant_dma;
    logic dma_blocked;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // On a tie the requester that did not win last time gets the memory.
    assign grant_dma   = dma_req && (!cpu_req || !last_grant_q);
    assign dma_blocked = dma_we && (dma_addr < PROT_BASE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        cpu_ack      = 1'b0;
        dma_ack      = 1'b0;
        dma_err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d      = grant_dma;
                    last_grant_d = grant_dma;
                    hold_we_d    = grant_dma ? dma_we    : cpu_we;
                    hold_addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    hold_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    cnt_d        = CNT_INIT;
                    if (grant_dma && dma_blocked) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                mem_en = 1'b1;
                // The counter still holds its load value only in the first access cycle.
                mem_we = hold_we_q && (cnt_q == CNT_INIT);
                if (cnt_q == 2'd0) begin
                    if (!hold_we_q) begin
                        if (owner_q) dma_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                cpu_ack = !owner_q;
                dma_ack = owner_q;
                dma_err = owner_q && err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign mem_addr  = hold_addr_q;
    assign mem_wdata = hold_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule
